// File: rtl/aes_ctr_if.sv
// aes_ctr_if: config, stream and status bundle of aes_ctr_engine.
// master = DMA side (source/sink), slave = engine.
interface aes_ctr_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 cfg_ld;
  logic [127:0]         key;
  logic [127:0]         iv;
  logic                 in_valid;
  logic                 in_ready;
  logic [127:0]         in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [127:0]         out_data;
  logic                 busy;
  logic [CNT_WIDTH-1:0] blk_cnt;
  logic                 err;

  modport master (
    output cfg_ld, key, iv, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, blk_cnt, err
  );

  modport slave (
    input  cfg_ld, key, iv, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, blk_cnt, err
  );
endinterface

// File: rtl/aes_ctr_engine.sv
// aes_ctr_engine: streaming AES-128 CTR around one iterative aes_cipher_top.
// Optional counter-wrap error: define AES_CTR_WRAP_ERR_EN.
module aes_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  output logic         done,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out
);
  logic [127:0] st_q, st_d, rk_q, rk_d, rk_n;
  logic [7:0]   rc_q, rc_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // inverse as a^254, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) t[i] = b[(i + 4*(i%4)) % 16];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else      o[127-32*c -: 32] = {
        xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
        xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] kstep(input logic [127:0] k,
                                         input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]),
          sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    st_d   = st_q;
    rk_d   = rk_q;
    rc_d   = rc_q;
    rnd_d  = rnd_q;
    done_d = 1'b0;
    rk_n   = kstep(rk_q, rc_q);
    if (ld) begin
      st_d  = text_in ^ key;
      rk_d  = key;
      rc_d  = 8'h01;
      rnd_d = 4'd1;
    end else if (rnd_q != 4'd0) begin
      st_d   = aes_round(st_q, rnd_q == 4'd10) ^ rk_n;
      rk_d   = rk_n;
      rc_d   = xt(rc_q);
      rnd_d  = (rnd_q == 4'd10) ? 4'd0 : rnd_q + 4'd1;
      done_d = (rnd_q == 4'd10);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= '0;
      rk_q   <= '0;
      rc_q   <= '0;
      rnd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      rk_q   <= rk_d;
      rc_q   <= rc_d;
      rnd_q  <= rnd_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign text_out = st_q;
endmodule

module aes_ctr_engine #(
  parameter int CTR_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  aes_ctr_if.slave io
);
  typedef enum logic [1:0] {IDLE, READY, WAIT, OUT} state_e;

  localparam logic [127:0] MASK = (128'd1 << CTR_WIDTH) - 128'd1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               st_q, st_d;
  logic [127:0]         key_q, key_d, ctr_q, ctr_d;
  logic [127:0]         data_q, data_d, out_q, out_d, ks;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ld_q, ld_d, err_q, err_d, done;
  logic                 cfg_ok, acc;

  aes_cipher_top u_core (
    .clk      (clk),
    .rst      (~rst),
    .ld       (ld_q),
    .done     (done),
    .key      (key_q),
    .text_in  (ctr_q),
    .text_out (ks)
  );

  always_comb begin
    st_d   = st_q;
    key_d  = key_q;
    ctr_d  = ctr_q;
    data_d = data_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    ld_d   = 1'b0;
    cfg_ok = io.cfg_ld && (st_q == IDLE || st_q == READY);
    acc    = io.in_ready && io.in_valid;
    unique case (st_q)
      IDLE, READY: begin
        if (cfg_ok) begin
          key_d = io.key;
          ctr_d = io.iv;
          cnt_d = '0;
          err_d = 1'b0;
          st_d  = READY;
        end else if (acc) begin
          data_d = io.in_data;
          ld_d   = 1'b1;
          st_d   = WAIT;
        end
      end
      // ld_q marks the first WAIT cycle, where done may be stale
      WAIT: if (!ld_q && done) begin
        out_d = data_q ^ ks;
        ctr_d = (ctr_q & ~MASK) | ((ctr_q + 128'd1) & MASK);
`ifdef AES_CTR_WRAP_ERR_EN
        if ((ctr_q & MASK) == MASK) err_d = 1'b1;
`endif
        st_d  = OUT;
      end
      OUT: if (io.out_ready) begin
        cnt_d = cnt_q + CNT_ONE;
        st_d  = READY;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      key_q  <= '0;
      ctr_q  <= '0;
      data_q <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      ld_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      key_q  <= key_d;
      ctr_q  <= ctr_d;
      data_q <= data_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      ld_q   <= ld_d;
      err_q  <= err_d;
    end
  end

  assign io.in_ready  = (st_q == READY) && !io.cfg_ld && !err_q;
  assign io.out_valid = (st_q == OUT);
  assign io.out_data  = out_q;
  assign io.busy      = (st_q == WAIT) || (st_q == OUT);
  assign io.blk_cnt   = cnt_q;
`ifdef AES_CTR_WRAP_ERR_EN
  assign io.err       = err_q;
`else
  assign io.err       = 1'b0;
`endif
endmodule
